pitch_scan_sequencer: RTL and testbench

//  Time-multiplexes the combinational pitch datapath (pitch_control) across all voice x oscillator slots.

---
 rtl/pitch_scan_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pitch_scan_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_scan_sequencer.sv
// Time-multiplexed pitch scan: walks every {voice,osc} slot through the shared pitch datapath
// and writes the settled result into the pitch table. Optional priority rescan: PITCH_SCAN_PRIORITY_EN.
//
// state   | meaning
// IDLE    | no work; pitch_idx holds last slot
// LOAD    | present selected slot to the datapath, arm settle timer
// WAIT    | settle timer counts down; capture pitch_in at terminal count
// CAPTURE | table write strobe high; advance slot selection
module pitch_scan_sequencer #(
   parameter int VOICES  = 8,
   parameter int V_OSC   = 4,
   parameter int V_WIDTH = 3,
   parameter int O_WIDTH = 2,
   parameter int SETTLE  = 3
) (
   input  logic                       sCLK_XVXENVS,
   input  logic                       iRST_N,
   input  logic                       run,
   input  logic                       cfg_write,
   input  logic                       note_on,
   input  logic [V_WIDTH-1:0]         key_adr,
   output logic [V_WIDTH+O_WIDTH-1:0] pitch_idx,
   input  logic [23:0]                pitch_in,
   output logic                       wr_en,
   output logic [V_WIDTH+O_WIDTH-1:0] wr_adr,
   output logic [23:0]                wr_data,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int IW = V_WIDTH + O_WIDTH;
   localparam logic [IW-1:0] LAST_SLOT = IW'(VOICES * V_OSC - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPTURE} state_t;

   state_t        state;
   logic [IW-1:0] rr_idx;
   logic [3:0]    cnt;
   logic          sweep_req;
   logic          sweep_act;
   logic          more;

`ifdef PITCH_SCAN_PRIORITY_EN
   localparam logic [O_WIDTH-1:0] OSC_LAST = O_WIDTH'(V_OSC - 1);

   logic [VOICES-1:0]  pend;
   logic [VOICES-1:0]  pend_set;
   logic               any_pend;
   logic [V_WIDTH-1:0] low_v;
   logic               prio_act;
   logic [V_WIDTH-1:0] prio_voice;
   logic [O_WIDTH-1:0] prio_osc;

   always_comb begin
      pend_set = note_on ? (VOICES'(1) << key_adr) : '0;
      any_pend = |pend;
      low_v    = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (pend[i]) low_v = V_WIDTH'(i);
      end
   end

   always_comb begin
      more = run | cfg_write | sweep_req | (sweep_act & ~frame_done) | any_pend | (|pend_set)
           | (prio_act & (prio_osc != OSC_LAST));
   end
`else
   logic unused_prio;
   assign unused_prio = ^{note_on, key_adr};

   always_comb begin
      more = run | cfg_write | sweep_req | (sweep_act & ~frame_done);
   end
`endif

   always_ff @(posedge sCLK_XVXENVS) begin
      if (!iRST_N) begin
         state      <= IDLE;
         pitch_idx  <= '0;
         rr_idx     <= '0;
         cnt        <= '0;
         wr_en      <= 1'b0;
         wr_adr     <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         sweep_req  <= 1'b0;
         sweep_act  <= 1'b0;
`ifdef PITCH_SCAN_PRIORITY_EN
         pend       <= '0;
         prio_act   <= 1'b0;
         prio_voice <= '0;
         prio_osc   <= '0;
`endif
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         if (cfg_write) sweep_req <= 1'b1;
`ifdef PITCH_SCAN_PRIORITY_EN
         pend <= pend | pend_set;
`endif
         case (state)
            IDLE: begin
`ifdef PITCH_SCAN_PRIORITY_EN
               if (run || sweep_req || any_pend) begin
`else
               if (run || sweep_req) begin
`endif
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end

            LOAD: begin
               cnt   <= 4'(SETTLE - 1);
               state <= WAIT;
`ifdef PITCH_SCAN_PRIORITY_EN
               if (prio_act) begin
                  pitch_idx <= {prio_voice, prio_osc};
               end else if (any_pend) begin
                  pitch_idx  <= {low_v, {O_WIDTH{1'b0}}};
                  prio_act   <= 1'b1;
                  prio_voice <= low_v;
                  prio_osc   <= '0;
                  pend       <= (pend & ~(VOICES'(1) << low_v)) | pend_set;
               end else
`endif
               begin
                  pitch_idx <= rr_idx;
                  // A sweep request is only taken at slot 0 so the sweep it starts is complete.
                  if (sweep_req && rr_idx == '0) begin
                     sweep_act <= 1'b1;
                     sweep_req <= cfg_write;
                  end
               end
            end

            WAIT: begin
               if (cnt == '0) begin
                  wr_data <= pitch_in;
                  wr_adr  <= pitch_idx;
                  wr_en   <= 1'b1;
`ifdef PITCH_SCAN_PRIORITY_EN
                  frame_done <= !prio_act && (pitch_idx == LAST_SLOT);
`else
                  frame_done <= (pitch_idx == LAST_SLOT);
`endif
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            CAPTURE: begin
`ifdef PITCH_SCAN_PRIORITY_EN
               if (prio_act) begin
                  if (prio_osc == OSC_LAST) prio_act <= 1'b0;
                  else                      prio_osc <= prio_osc + 1'b1;
               end else
`endif
               begin
                  rr_idx <= (rr_idx == LAST_SLOT) ? '0 : rr_idx + 1'b1;
               end
               if (frame_done) sweep_act <= 1'b0;
               if (more) begin
                  state <= LOAD;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_scan_sequencer.sv
// Scoreboard bench for pitch_scan_sequencer: expected table writes are queued by the stimulus
// and consumed by a write monitor; expectations follow PITCH_SCAN_PRIORITY_EN.
module tb_pitch_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        cfg_write;
   logic        note_on;
   logic [2:0]  key_adr;
   logic [4:0]  pitch_idx;
   logic [23:0] pitch_in;
   logic        wr_en;
   logic [4:0]  wr_adr;
   logic [23:0] wr_data;
   logic        busy;
   logic        frame_done;

   pitch_scan_sequencer dut (
      .sCLK_XVXENVS (clk),
      .iRST_N       (rst_n),
      .run          (run),
      .cfg_write    (cfg_write),
      .note_on      (note_on),
      .key_adr      (key_adr),
      .pitch_idx    (pitch_idx),
      .pitch_in     (pitch_in),
      .wr_en        (wr_en),
      .wr_adr       (wr_adr),
      .wr_data      (wr_data),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: pitch of slot s is s*100.
   assign pitch_in = {19'd0, pitch_idx} * 24'd100;

   typedef struct packed {
      logic [4:0]  adr;
      logic [23:0] data;
      logic        fd;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_wr   = 0;
   int   cyc    = 0;
   int   last_wr = 0;
   bit   per_arm = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_slot(input int adr, input bit fd);
      exp_t e;
      e.adr  = 5'(adr);
      e.data = 24'(adr * 100);
      e.fd   = fd;
      exp_q.push_back(e);
   endtask

   task automatic push_rr(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) push_slot(i, i == 31);
   endtask

   task automatic push_voice(input int v);
      for (int o = 0; o < 4; o++) push_slot(v * 4 + o, 1'b0);
   endtask

   // Write monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!busy && !wr_en) per_arm = 0;
         if (wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: adr=%0d data=%0d, queue empty", wr_adr, wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_adr", 32'(wr_adr), 32'(e.adr));
               chk("wr_data", 32'(wr_data), 32'(e.data));
               chk("frame_done", 32'(frame_done), 32'(e.fd));
            end
            if (per_arm) chk("slot_period", 32'(cyc - last_wr), 32'd5);
            last_wr = cyc;
            per_arm = 1;
         end else if (frame_done) begin
            chk("stray_frame_done", 32'(frame_done), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wr(input int adr);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(wr_en === 1'b1 && wr_adr == 5'(adr)) && n < 400);
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL wait_write: slot %0d not written within 400 cycles", adr);
      end
   endtask

   task automatic settle_idle(input string name, input int base, input int exp_n);
      repeat (3) tick();
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_writes"}, 32'(n_wr - base), 32'(exp_n));
      chk({name, "_queue"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; run = 1'b0; cfg_write = 1'b0; note_on = 1'b0; key_adr = '0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_pitch_idx", 32'(pitch_idx), 32'd0);
      chk("rst_wr_adr", 32'(wr_adr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      tick();

      // Continuous run: one full frame, then stop at slot 31.
      base = n_wr;
      push_rr(0, 31);
      run = 1'b1;
      wait_wr(31);
      run = 1'b0;
      settle_idle("run_frame", base, 32);
      chk("idle_hold_idx", 32'(pitch_idx), 32'd31);

      // Single cfg_write sweep.
      base = n_wr;
      push_rr(0, 31);
      cfg_write = 1'b1; tick(); cfg_write = 1'b0;
      wait_wr(31);
      settle_idle("cfg_sweep", base, 32);

      // cfg_write during write #10 adds a second full sweep.
      base = n_wr;
      push_rr(0, 31);
      push_rr(0, 31);
      cfg_write = 1'b1; tick(); cfg_write = 1'b0;
      wait_wr(9);
      cfg_write = 1'b1; tick(); cfg_write = 1'b0;
      wait_wr(31);
      wait_wr(31);
      settle_idle("cfg_double", base, 64);

      // Reset during WAIT of slot 7.
      base = n_wr;
      push_rr(0, 6);
      run = 1'b1;
      wait_wr(6);
      tick();
      tick();
      chk("pre_rst_idx", 32'(pitch_idx), 32'd7);
      rst_n = 1'b0; run = 1'b0;
      tick();
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_idx", 32'(pitch_idx), 32'd0);
      rst_n = 1'b1;
      repeat (20) tick();
      chk("mid_rst_writes", 32'(n_wr - base), 32'd7);
      chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);

      // note_on voice 5 during slot 2.
      base = n_wr;
`ifdef PITCH_SCAN_PRIORITY_EN
      push_rr(0, 2);
      push_voice(5);
      push_rr(3, 31);
`else
      push_rr(0, 31);
`endif
      run = 1'b1;
      wait_wr(1);
      tick();
      tick();
      note_on = 1'b1; key_adr = 3'd5; tick(); note_on = 1'b0;
      wait_wr(31);
      run = 1'b0;
`ifdef PITCH_SCAN_PRIORITY_EN
      settle_idle("prio_one", base, 36);
`else
      settle_idle("prio_one", base, 32);
`endif

      // note_on voice 6 then voice 1 in consecutive cycles during slot 0.
      base = n_wr;
`ifdef PITCH_SCAN_PRIORITY_EN
      push_rr(0, 0);
      push_voice(1);
      push_voice(6);
      push_rr(1, 31);
`else
      push_rr(0, 31);
`endif
      run = 1'b1;
      tick();
      tick();
      note_on = 1'b1; key_adr = 3'd6; tick();
      key_adr = 3'd1; tick();
      note_on = 1'b0;
      wait_wr(31);
      run = 1'b0;
`ifdef PITCH_SCAN_PRIORITY_EN
      settle_idle("prio_two", base, 40);
`else
      settle_idle("prio_two", base, 32);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
